// File: rtl/vid_timing_pkg.sv
// Shared definitions for the video timing generator.
// Holds the colour-bar component masks (bit b set = component on for bar b),
// a packed struct describing one raster timing, and a bar-to-RGB helper.
package vid_timing_pkg;

  // Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0] BAR_R_MASK = 8'b0011_0011;  // bars 0,1,4,5
  localparam logic [7:0] BAR_G_MASK = 8'b0000_1111;  // bars 0,1,2,3
  localparam logic [7:0] BAR_B_MASK = 8'b0101_0101;  // bars 0,2,4,6

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } timing_t;

  // Returns {r_on, g_on, b_on} for a bar index.
  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    return {BAR_R_MASK[bar], BAR_G_MASK[bar], BAR_B_MASK[bar]};
  endfunction

endpackage

// File: rtl/vid_ce_div.sv
// Pixel clock-enable divider.
// Ports: clk, reset_n (async, active-low), enable (run/freeze),
//        pix_ce (one-clk strobe every CE_DIV enabled clks).
module vid_ce_div #(
  parameter int unsigned CE_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic pix_ce
);

  localparam int unsigned CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_c;

  assign last_c = (cnt_q == CW'(CE_DIV - 1));

  // Count only while enabled so a freeze resumes on the same phase.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = last_c ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // reset_n term only matters for CE_DIV=1, where the count is always "last".
  assign pix_ce = enable & last_c & reset_n;

endmodule

// File: rtl/vid_timing_gen.sv
// Raster video timing generator with optional colour-bar test pattern.
// Optional feature macro: VID_TIMING_PATTERN_EN (8 vertical colour bars on
// active pixels); when undefined red/green/blue are tied to 0.
// Ports: clk, reset_n (async, active-low), enable (run/freeze);
//        pix_ce, frame_start (strobes); hblank, vblank, hs, vs, hpos, vpos,
//        red, green, blue (registered on pix_ce, one pixel behind counters).
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned VIDEO_DEPTH = 8,
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 32,
  parameter int unsigned H_BP        = 40,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned V_FP        = 3,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BP        = 16,
  parameter int unsigned CE_DIV      = 4,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW         = $clog2(H_TOTAL),
  localparam int unsigned VW         = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic                   pix_ce,
  output logic                   hblank,
  output logic                   vblank,
  output logic                   hs,
  output logic                   vs,
  output logic [HW-1:0]          hpos,
  output logic [VW-1:0]          vpos,
  output logic [VIDEO_DEPTH-1:0] red,
  output logic [VIDEO_DEPTH-1:0] green,
  output logic [VIDEO_DEPTH-1:0] blue,
  output logic                   frame_start
);

  localparam timing_t TIM = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  };

  // Sync windows as half-open ranges [BEG, END), compared at 32 bits.
  localparam int unsigned HS_BEG = 32'(TIM.h_active) + 32'(TIM.h_fp);
  localparam int unsigned HS_END = HS_BEG + 32'(TIM.h_sync);
  localparam int unsigned VS_BEG = 32'(TIM.v_active) + 32'(TIM.v_fp);
  localparam int unsigned VS_END = VS_BEG + 32'(TIM.v_sync);

  logic          pix_ce_c;
  logic [HW-1:0] hcnt_q, hcnt_d, hpos_q;
  logic [VW-1:0] vcnt_q, vcnt_d, vpos_q;
  logic          hblank_q, hblank_d, vblank_q, vblank_d;
  logic          hs_q, hs_d, vs_q, vs_d;

  vid_ce_div #(
    .CE_DIV (CE_DIV)
  ) u_ce_div (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .pix_ce  (pix_ce_c)
  );

  // Raster counters: vertical advances on the horizontal wrap.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_ce_c) begin
      if (hcnt_q == HW'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  // Timing decode of the current (pre-increment) counters.
  always_comb begin
    hblank_d = (32'(hcnt_q) >= H_ACTIVE);
    vblank_d = (32'(vcnt_q) >= V_ACTIVE);
    hs_d     = ((32'(hcnt_q) >= HS_BEG) && (32'(hcnt_q) < HS_END)) ? HS_POL : ~HS_POL;
    vs_d     = ((32'(vcnt_q) >= VS_BEG) && (32'(vcnt_q) < VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hpos_q   <= '0;
      vpos_q   <= '0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (pix_ce_c) begin
        hpos_q   <= hcnt_q;
        vpos_q   <= vcnt_q;
        hblank_q <= hblank_d;
        vblank_q <= vblank_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
      end
    end
  end

  assign pix_ce      = pix_ce_c;
  assign frame_start = pix_ce_c && (hcnt_q == '0) && (vcnt_q == '0);
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;

`ifdef VID_TIMING_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]             bar_c, rgb_on_c;
  logic [VIDEO_DEPTH-1:0] red_q, green_q, blue_q;

  // Bar index from pixel column; blanked pixels forced black.
  always_comb begin
    bar_c    = 3'(32'(hcnt_q) / BAR_W);
    rgb_on_c = (hblank_d || vblank_d) ? 3'b000 : bar_rgb(bar_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pix_ce_c) begin
      red_q   <= {VIDEO_DEPTH{rgb_on_c[2]}};
      green_q <= {VIDEO_DEPTH{rgb_on_c[1]}};
      blue_q  <= {VIDEO_DEPTH{rgb_on_c[0]}};
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
`else
  assign red   = '0;
  assign green = '0;
  assign blue  = '0;
`endif

endmodule
